// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : register map, status bit indices and FSM encoding for uart_ctrl
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam logic [12:0] UART_RX   = 13'h0;
  localparam logic [12:0] UART_TX   = 13'h4;
  localparam logic [12:0] UART_STAT = 13'h8;

  localparam int STAT_RXVALID = 0;
  localparam int STAT_TXFULL  = 3;

  // Direction encoding shared by the arbiter and the controller
  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ST_AR = 3'd1,
    ST_R  = 3'd2,
    RX_AR = 3'd3,
    RX_R  = 3'd4,
    TX_AW = 3'd5,
    TX_B  = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_ctrl_if.sv
`default_nettype none
// ============================================================================
// uart_ctrl_if : AXI4-Lite master port towards the UART Lite register block
// Revision     : 1.0
// ============================================================================
interface uart_ctrl_if;

  logic [12:0] uart_araddr;
  logic        uart_arvalid;
  logic        uart_arready;
  logic [31:0] uart_rdata;
  logic [1:0]  uart_rresp;
  logic        uart_rvalid;
  logic        uart_rready;
  logic [12:0] uart_awaddr;
  logic        uart_awvalid;
  logic        uart_awready;
  logic [31:0] uart_wdata;
  logic [3:0]  uart_wstrb;
  logic        uart_wvalid;
  logic        uart_wready;
  logic [1:0]  uart_bresp;
  logic        uart_bvalid;
  logic        uart_bready;

  modport master (
    output uart_araddr, uart_arvalid, input  uart_arready,
    input  uart_rdata,  uart_rresp,   uart_rvalid, output uart_rready,
    output uart_awaddr, uart_awvalid, input  uart_awready,
    output uart_wdata,  uart_wstrb,   uart_wvalid, input  uart_wready,
    input  uart_bresp,  uart_bvalid,  output uart_bready
  );

  modport slave (
    input  uart_araddr, uart_arvalid, output uart_arready,
    output uart_rdata,  uart_rresp,   uart_rvalid, input  uart_rready,
    input  uart_awaddr, uart_awvalid, output uart_awready,
    input  uart_wdata,  uart_wstrb,   uart_wvalid, output uart_wready,
    output uart_bresp,  uart_bvalid,  input  uart_bready
  );

endinterface
`default_nettype wire

// File: rtl/uart_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2  : two-requester round-robin arbiter; req/gnt bit 0 = read, 1 = write
// Revision : 1.0
// ============================================================================
module rr_arb2 (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] req_i,
  input  wire logic       en_i,
  output logic      [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (last_q == 1'b1) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
      if (gnt_o != 2'b00) begin
        last_d = gnt_o[1];
      end
    end
  end

  // Reset to "write granted last" so the first contention favours read
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_ctrl.sv
`default_nettype none
// ============================================================================
// uart_ctrl : sequences byte RX/TX requests onto an AXI4-Lite UART Lite slave,
//             polling STAT before every FIFO access, one transaction at a time
// Revision  : 1.0
// ============================================================================
module uart_ctrl
  import uart_pkg::*;
#(
  parameter logic [12:0] BASE_ADDR = 13'h0,
  parameter int          POLL_GAP  = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       renable,
  output logic            rdone,
  output logic      [7:0] rdata,
  input  wire logic       wenable,
  input  wire logic [7:0] wdata,
  output logic            wdone,
  output logic            bus_err,
  uart_ctrl_if.master     axi
);

  localparam int               BO_W      = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [BO_W-1:0]  BO_LOAD   = BO_W'(POLL_GAP);
  localparam logic [BO_W-1:0]  BO_ONE    = BO_W'(1);
  localparam logic [12:0]      ADDR_RX   = BASE_ADDR + UART_RX;
  localparam logic [12:0]      ADDR_TX   = BASE_ADDR + UART_TX;
  localparam logic [12:0]      ADDR_STAT = BASE_ADDR + UART_STAT;

  state_e            state_q, state_d;
  logic              rpend_q, rpend_d;
  logic              wpend_q, wpend_d;
  logic [7:0]        wbuf_q, wbuf_d;
  logic [BO_W-1:0]   rbo_q, rbo_d;
  logic [BO_W-1:0]   wbo_q, wbo_d;
  logic              gdir_q, gdir_d;
  logic              aw_ok_q, aw_ok_d;
  logic              w_ok_q, w_ok_d;
  logic              rdone_q, rdone_d;
  logic              wdone_q, wdone_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              r_elig, w_elig;
  logic [1:0]        gnt;

  logic [12:0]       araddr_w, awaddr_w;
  logic              arvalid_w, rready_w, awvalid_w, wvalid_w, bready_w;
  logic [31:0]       wdata_w;

  logic              unused_rdata_hi;
  assign unused_rdata_hi = &{1'b0, axi.uart_rdata[31:8]};

  assign r_elig = (renable || rpend_q) && (rbo_q == '0);
  assign w_elig = (wenable || wpend_q) && (wbo_q == '0);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({w_elig, r_elig}),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d   = state_q;
    rpend_d   = rpend_q;
    wpend_d   = wpend_q;
    wbuf_d    = wbuf_q;
    rbo_d     = (rbo_q != '0) ? (rbo_q - BO_ONE) : rbo_q;
    wbo_d     = (wbo_q != '0) ? (wbo_q - BO_ONE) : wbo_q;
    gdir_d    = gdir_q;
    aw_ok_d   = aw_ok_q;
    w_ok_d    = w_ok_q;
    rdone_d   = 1'b0;
    wdone_d   = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    arvalid_w = 1'b0;
    araddr_w  = 13'h0;
    rready_w  = 1'b0;
    awvalid_w = 1'b0;
    awaddr_w  = 13'h0;
    wvalid_w  = 1'b0;
    wdata_w   = 32'h0;
    bready_w  = 1'b0;

    // A pulse against an already-set latch is dropped; the first request wins
    if (renable) begin
      rpend_d = 1'b1;
    end
    if (wenable && !wpend_q) begin
      wpend_d = 1'b1;
      wbuf_d  = wdata;
    end

    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          state_d = ST_AR;
          gdir_d  = gnt[1] ? DIR_WR : DIR_RD;
        end
      end
      ST_AR: begin
        arvalid_w = 1'b1;
        araddr_w  = ADDR_STAT;
        if (axi.uart_arready) begin
          state_d = ST_R;
        end
      end
      ST_R: begin
        rready_w = 1'b1;
        if (axi.uart_rvalid) begin
          if (axi.uart_rresp != 2'b00) begin
            err_d = 1'b1;
          end
          if (gdir_q == DIR_RD && axi.uart_rdata[STAT_RXVALID]) begin
            state_d = RX_AR;
          end else if (gdir_q == DIR_WR && !axi.uart_rdata[STAT_TXFULL]) begin
            state_d = TX_AW;
            aw_ok_d = 1'b0;
            w_ok_d  = 1'b0;
          end else begin
            state_d = IDLE;
            if (gdir_q == DIR_WR) begin
              wbo_d = BO_LOAD;
            end else begin
              rbo_d = BO_LOAD;
            end
          end
        end
      end
      RX_AR: begin
        arvalid_w = 1'b1;
        araddr_w  = ADDR_RX;
        if (axi.uart_arready) begin
          state_d = RX_R;
        end
      end
      RX_R: begin
        rready_w = 1'b1;
        if (axi.uart_rvalid) begin
          if (axi.uart_rresp != 2'b00) begin
            err_d = 1'b1;
          end
          state_d = IDLE;
          rdone_d = 1'b1;
          rdata_d = axi.uart_rdata[7:0];
          rpend_d = 1'b0;
        end
      end
      TX_AW: begin
        // AW and W complete independently; each valid drops after its own handshake
        awvalid_w = !aw_ok_q;
        wvalid_w  = !w_ok_q;
        awaddr_w  = ADDR_TX;
        wdata_w   = {24'h0, wbuf_q};
        if (awvalid_w && axi.uart_awready) begin
          aw_ok_d = 1'b1;
        end
        if (wvalid_w && axi.uart_wready) begin
          w_ok_d = 1'b1;
        end
        if ((aw_ok_q || axi.uart_awready) && (w_ok_q || axi.uart_wready)) begin
          state_d = TX_B;
        end
      end
      TX_B: begin
        bready_w = 1'b1;
        if (axi.uart_bvalid) begin
          if (axi.uart_bresp != 2'b00) begin
            err_d = 1'b1;
          end
          state_d = IDLE;
          wdone_d = 1'b1;
          wpend_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rpend_q <= 1'b0;
      wpend_q <= 1'b0;
      wbuf_q  <= 8'h0;
      rbo_q   <= '0;
      wbo_q   <= '0;
      gdir_q  <= DIR_RD;
      aw_ok_q <= 1'b0;
      w_ok_q  <= 1'b0;
      rdone_q <= 1'b0;
      wdone_q <= 1'b0;
      rdata_q <= 8'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rpend_q <= rpend_d;
      wpend_q <= wpend_d;
      wbuf_q  <= wbuf_d;
      rbo_q   <= rbo_d;
      wbo_q   <= wbo_d;
      gdir_q  <= gdir_d;
      aw_ok_q <= aw_ok_d;
      w_ok_q  <= w_ok_d;
      rdone_q <= rdone_d;
      wdone_q <= wdone_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rdone   = rdone_q;
  assign wdone   = wdone_q;
  assign rdata   = rdata_q;
  assign bus_err = err_q;

  assign axi.uart_araddr  = araddr_w;
  assign axi.uart_arvalid = arvalid_w;
  assign axi.uart_rready  = rready_w;
  assign axi.uart_awaddr  = awaddr_w;
  assign axi.uart_awvalid = awvalid_w;
  assign axi.uart_wdata   = wdata_w;
  assign axi.uart_wstrb   = 4'b0001;
  assign axi.uart_wvalid  = wvalid_w;
  assign axi.uart_bready  = bready_w;

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
// ============================================================================
// tb_uart_ctrl : directed stimulus, behavioural AXI-Lite UART slave, scoreboard
// Revision     : 1.0
// ============================================================================
module tb_uart_ctrl;

  localparam int POLL_GAP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       renable, wenable;
  logic [7:0] wdata;
  logic       rdone, wdone, bus_err;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  uart_ctrl_if axi ();

  uart_ctrl #(.BASE_ADDR(13'h0), .POLL_GAP(POLL_GAP)) dut (
    .clk     (clk),
    .rst     (rst),
    .renable (renable),
    .rdone   (rdone),
    .rdata   (rdata),
    .wenable (wenable),
    .wdata   (wdata),
    .wdone   (wdone),
    .bus_err (bus_err),
    .axi     (axi)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic fail_evt(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    bit         wr;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(bit wr, logic [7:0] d, int at);
    exp_t e;
    e.wr = wr; e.data = d; e.at = at;
    sb.push_back(e);
  endtask

  // ---------------- slave model state ----------------
  logic [31:0] stat_q[$];
  logic [31:0] stat_default = 32'h0;
  logic [31:0] rx_val       = 32'h0;
  int          aw_delay     = 0;
  logic [1:0]  bresp_cfg    = 2'b00;
  logic [12:0] ar_log[$];
  int          ar_cyc[$];
  logic [7:0]  last_wbyte   = 8'h0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;

  logic        p_arv = 0, p_arr = 0, p_rv = 0, p_rr = 0, p_awv = 0, p_awr = 0;
  logic        p_wv = 0, p_wr = 0, p_bv = 0, p_br = 0;
  logic [12:0] p_araddr = 0;
  logic [31:0] p_wdata = 0;

  // Handshakes are judged from the values held over the preceding posedge
  initial begin : slave
    bit aw_got, w_got;
    int aw_wait;
    aw_got = 0; w_got = 0; aw_wait = 0;
    axi.uart_arready = 0; axi.uart_rvalid = 0; axi.uart_rdata = 0; axi.uart_rresp = 0;
    axi.uart_awready = 0; axi.uart_wready = 0; axi.uart_bvalid = 0; axi.uart_bresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axi.uart_arready = 0; axi.uart_rvalid = 0; axi.uart_awready = 0;
        axi.uart_wready = 0; axi.uart_bvalid = 0;
        aw_got = 0; w_got = 0; aw_wait = 0;
      end else begin
        if (p_rv && p_rr) axi.uart_rvalid = 0;
        if (p_arv && p_arr) begin
          ar_log.push_back(p_araddr);
          ar_cyc.push_back(cyc - 1);
          axi.uart_rvalid = 1;
          axi.uart_rresp  = 2'b00;
          if (p_araddr == 13'h8)
            axi.uart_rdata = (stat_q.size() > 0) ? stat_q.pop_front() : stat_default;
          else
            axi.uart_rdata = rx_val;
        end
        axi.uart_arready = axi.uart_arvalid;
        if (p_awv && p_awr) aw_got = 1;
        if (p_wv && p_wr) begin
          w_got = 1;
          last_wbyte = p_wdata[7:0];
        end
        if (p_bv && p_br) axi.uart_bvalid = 0;
        if (aw_got && w_got) begin
          axi.uart_bvalid = 1;
          axi.uart_bresp  = bresp_cfg;
          aw_got = 0; w_got = 0; aw_wait = 0;
        end
        axi.uart_awready = axi.uart_awvalid && (aw_wait >= aw_delay);
        if (axi.uart_awvalid && !axi.uart_awready) aw_wait++;
        axi.uart_wready = axi.uart_wvalid;
      end
      p_arv = axi.uart_arvalid; p_arr = axi.uart_arready; p_araddr = axi.uart_araddr;
      p_rv  = axi.uart_rvalid;  p_rr  = axi.uart_rready;
      p_awv = axi.uart_awvalid; p_awr = axi.uart_awready;
      p_wv  = axi.uart_wvalid;  p_wr  = axi.uart_wready;  p_wdata = axi.uart_wdata;
      p_bv  = axi.uart_bvalid;  p_br  = axi.uart_bready;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (rdone && wdone) begin
        fail_evt("rdone_wdone_same_cycle");
      end else if (rdone || wdone) begin
        if (sb.size() == 0) begin
          fail_evt("unexpected_done");
        end else begin
          e = sb.pop_front();
          check("done_kind_is_write", {31'h0, wdone}, {31'h0, e.wr});
          check("done_data", {24'h0, (rdone ? rdata : last_wbyte)}, {24'h0, e.data});
          if (e.at >= 0) check("done_cycle", cyc, e.at);
        end
      end
      if (axi.uart_awvalid) begin
        aw_cnt++;
        check("awaddr", {19'h0, axi.uart_awaddr}, 32'h4);
      end
      if (axi.uart_wvalid) begin
        w_cnt++;
        check("wdata_upper", {8'h0, axi.uart_wdata[31:8]}, 32'h0);
        check("wstrb", {28'h0, axi.uart_wstrb}, 32'h1);
      end
      if (axi.uart_bready) b_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_sb(int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("scoreboard_drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_logs();
    ar_log.delete(); ar_cyc.delete();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c0;
    rst = 1'b1; renable = 0; wenable = 0; wdata = 8'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valids_readies", {27'h0, axi.uart_arvalid, axi.uart_rready, axi.uart_awvalid,
                                 axi.uart_wvalid, axi.uart_bready}, 32'h0);
    check("rst_done_err", {29'h0, rdone, wdone, bus_err}, 32'h0);
    check("rst_rdata", {24'h0, rdata}, 32'h0);
    check("rst_wstrb", {28'h0, axi.uart_wstrb}, 32'h1);
    check("rst_addrs", {6'h0, axi.uart_araddr, axi.uart_awaddr}, 32'h0);
    check("rst_wdata", axi.uart_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Read with RX ready
    clear_logs();
    stat_q.push_back(32'h1); rx_val = 32'h41;
    c0 = cyc;
    push_exp(1'b0, 8'h41, c0 + 5);
    renable = 1; @(negedge clk); renable = 0;
    wait_sb(50);
    check("rd_ar_count", ar_log.size(), 2);
    check("rd_ar0_stat", {19'h0, ar_log[0]}, 32'h8);
    check("rd_ar1_rx",   {19'h0, ar_log[1]}, 32'h0);
    check("rd_star_cycle", ar_cyc[0], c0 + 1);

    // Write with TX not full
    clear_logs();
    stat_default = 32'h0;
    c0 = cyc;
    push_exp(1'b1, 8'h5A, c0 + 5);
    wdata = 8'h5A; wenable = 1; @(negedge clk); wenable = 0; wdata = 8'h00;
    wait_sb(50);
    check("wr_aw_cycles", aw_cnt, 1);
    check("wr_w_cycles",  w_cnt, 1);
    check("wr_b_cycles",  b_cnt, 1);
    check("wr_ar_count",  ar_log.size(), 1);

    // Back-off: three not-ready polls then ready
    clear_logs();
    stat_q.push_back(32'h0); stat_q.push_back(32'h0); stat_q.push_back(32'h0);
    stat_q.push_back(32'h1);
    rx_val = 32'h33;
    push_exp(1'b0, 8'h33, -1);
    renable = 1; @(negedge clk); renable = 0;
    wait_sb(200);
    check("bo_ar_count", ar_log.size(), 5);
    for (int i = 0; i < 4; i++) check("bo_poll_addr", {19'h0, ar_log[i]}, 32'h8);
    check("bo_rx_addr", {19'h0, ar_log[4]}, 32'h0);
    for (int i = 1; i < 4; i++)
      check("bo_poll_spacing_ok", {31'h0, (ar_cyc[i] - ar_cyc[i-1]) >= (POLL_GAP + 1)}, 32'h1);

    // Contention after reset: read first; then a second pair arriving in the
    // rdone cycle finds write pending and read last-granted, so write goes
    // next; the second wenable is dropped because the write latch is set.
    do_reset();
    @(negedge clk);
    stat_default = 32'h1; rx_val = 32'h11;
    c0 = cyc;
    push_exp(1'b0, 8'h11, c0 + 5);
    push_exp(1'b1, 8'h77, c0 + 10);
    push_exp(1'b0, 8'h22, c0 + 15);
    renable = 1; wenable = 1; wdata = 8'h77;
    @(negedge clk);
    renable = 0; wenable = 0;
    repeat (4) @(negedge clk);
    renable = 1; wenable = 1; wdata = 8'hEE; rx_val = 32'h22;
    @(negedge clk);
    renable = 0; wenable = 0;
    wait_sb(100);

    // Independent AW/W handshakes with SLVERR response
    clear_logs();
    stat_default = 32'h0; aw_delay = 3; bresp_cfg = 2'b10;
    c0 = cyc;
    push_exp(1'b1, 8'hC3, c0 + 8);
    wdata = 8'hC3; wenable = 1; @(negedge clk); wenable = 0;
    wait_sb(60);
    check("aww_aw_cycles", aw_cnt, 4);
    check("aww_w_cycles",  w_cnt, 1);
    check("aww_b_cycles",  b_cnt, 1);
    check("aww_bus_err",   {31'h0, bus_err}, 32'h1);
    aw_delay = 0; bresp_cfg = 2'b00;

    // Reset in RX_R
    stat_q.push_back(32'h1); rx_val = 32'h55;
    renable = 1; @(negedge clk); renable = 0;
    repeat (3) @(negedge clk);
    check("rxr_rready_before_rst", {31'h0, axi.uart_rready}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rxr_rst_valids_readies", {27'h0, axi.uart_arvalid, axi.uart_rready, axi.uart_awvalid,
                                     axi.uart_wvalid, axi.uart_bready}, 32'h0);
    check("rxr_rst_bus_err", {31'h0, bus_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("rxr_no_leftover_expect", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_ctrl.md
# uart_ctrl

Sequencing controller between the core's byte-oriented UART requests and an AXI4-Lite UART Lite slave (13-bit address space: RX FIFO 0x0, TX FIFO 0x4, STAT 0x8). It polls STAT before every FIFO access and drains RX or fills TX only when the FIFO is ready. When read and write requests are both pending, it shares the single AXI master port between them round-robin. Exactly one AXI transaction is in flight at any time.

## Interface
- `BASE_ADDR`, 13'h0: base of the UART Lite register block; offsets are added modulo 2^13.
- `POLL_GAP`, 4: idle cycles the controller waits before re-polling a direction whose FIFO was not ready (0 = re-poll immediately).
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `renable` in 1: one-cycle pulse requesting one received byte.
- `rdone` out 1: one-cycle pulse; `rdata` is valid in the same cycle.
- `rdata` out 8: received byte, taken from RX FIFO bits [7:0].
- `wenable` in 1: one-cycle pulse requesting transmission of `wdata`.
- `wdata` in 8: byte to send; captured in the cycle `wenable` is high.
- `wdone` out 1: one-cycle pulse once the TX write response has been received.
- `bus_err` out 1: sticky; set by any `rresp` or `bresp` not equal to 2'b00.
- `uart_araddr` out 13, `uart_arvalid` out 1, `uart_arready` in 1: AXI read-address channel.
- `uart_rdata` in 32, `uart_rresp` in 2, `uart_rvalid` in 1, `uart_rready` out 1: AXI read-data channel.
- `uart_awaddr` out 13, `uart_awvalid` out 1, `uart_awready` in 1: AXI write-address channel.
- `uart_wdata` out 32, `uart_wstrb` out 4, `uart_wvalid` out 1, `uart_wready` in 1: AXI write-data channel.
- `uart_bresp` in 2, `uart_bvalid` in 1, `uart_bready` out 1: AXI write-response channel.

## Operation
- Request latches `rpend` / `wpend`:
  - Set by `renable` / `wenable`; `wdata` is stored in `wbuf`.
  - A pulse that arrives while its own latch is already set is dropped; the first request is kept.
  - Cleared in the cycle the matching `rdone` / `wdone` pulses.
- Eligibility: in IDLE, a direction is eligible when (its pulse is high this cycle or its latch is set) and its back-off counter is 0.
- Arbitration in IDLE:
  - One eligible direction: grant it.
  - Both eligible: grant the direction not in `last_grant`. `last_grant` is updated at every grant. Reset value selects read first.
- States:
  - IDLE
  - ST_AR: `arvalid`=1, `araddr`=BASE+0x8.
  - ST_R: `rready`=1.
  - RX_AR: `araddr`=BASE+0x0.
  - RX_R
  - TX_AW: `awvalid` and `wvalid` raised together, `awaddr`=BASE+0x4, `wdata`={24'h0,`wbuf`}, `wstrb`=4'b0001.
  - TX_B: `bready`=1.
- Transitions:
  - IDLE → ST_AR on grant.
  - ST_AR → ST_R on `arready`.
  - ST_R on `rvalid`:
    - Read grant with STAT[0]=1 (RX valid) → RX_AR.
    - Write grant with STAT[3]=0 (TX not full) → TX_AW.
    - Otherwise → IDLE, and the granted direction's back-off counter is loaded with POLL_GAP.
  - RX_AR → RX_R on `arready`.
  - RX_R → IDLE on `rvalid`; `rdone` pulses and `rdata` is loaded with `uart_rdata[7:0]`.
  - TX_AW:
    - `awvalid` and `wvalid` each drop independently when their own ready is seen.
    - Leave for TX_B once both handshakes have completed; they may complete in the same cycle or in different cycles.
  - TX_B → IDLE on `bvalid`; `wdone` pulses.
- Back-off counters: one per direction. They decrement every cycle while nonzero, including outside IDLE.
- AXI rules:
  - Every valid is held until its handshake completes.
  - Address and data outputs are stable while their valid is high.
  - Response codes other than OKAY still complete the operation; they only set `bus_err`.

## Timing
- Reset values:
  - State IDLE; `rpend`, `wpend`, back-off counters = 0; `last_grant` = write.
  - All valid/ready outputs, `rdone`, `wdone`, `bus_err` = 0.
  - `rdata` = 8'h0; `uart_wstrb` = 4'b0001; all addresses and `uart_wdata` = 0.
- Reset mid-transaction aborts immediately. Pending requests are lost, and no `rdone`/`wdone` is issued for them.
- Latency with a zero-wait slave, request pulse in cycle N:
  - ST_AR in N+1.
  - `rdone` in N+5 (ST_R N+2, RX_AR N+3, RX_R N+4).
  - `wdone` in N+5 (TX_AW N+3, TX_B N+4).
- A new grant can be issued in the same cycle the previous `rdone`/`wdone` pulses.
- `rdone` and `wdone` are never high in the same cycle.

## Structure
- Shared package `uart_pkg`:
  - Register offsets `UART_RX`=13'h0, `UART_TX`=13'h4, `UART_STAT`=13'h8.
  - Status bit indices `STAT_RXVALID`=0, `STAT_TXFULL`=3.
  - The state enumeration.
- One sub-module, `rr_arb2`: 2-requester round-robin arbiter with a grant-enable input and a `last_grant` register. Everything else stays in `uart_ctrl`.

## Test plan
- Read, RX ready: `renable` in cycle 0; slave returns STAT=32'h1, then RX=32'h41 → `rdone` in cycle 5 with `rdata`=8'h41; `araddr` sequence is 0x8 then 0x0.
- Write, TX not full: `wenable` with `wdata`=8'h5A; STAT=32'h0 → one AW/W at 0x4 with `wdata`=32'h5A and `wstrb`=4'b0001; `wdone` in cycle 5.
- Back-off: read with STAT=32'h0 for three polls, then 32'h1. Polls must be spaced ≥ POLL_GAP+1 cycles apart; exactly one `rdone` and no RX read before the ready poll.
- Contention: `renable` and `wenable` in the same cycle after reset → read served first, then write. Repeat both → write served first.
- Independent AW/W handshakes: `awready` 3 cycles late, `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` held 4 cycles; a single `bready` phase follows. `bresp`=2'b10 → `bus_err`=1, `wdone` still pulses.
- Reset mid-operation: `rst` asserted in RX_R → next cycle all valid/ready outputs are 0; no `rdone` follows.
